// File: rtl/pipe_pkg.sv
// Shared types for the ID->EX control-word interface: entry layout and EX-stage states.
package pipe_pkg;
    localparam int CW_W   = 17;
    localparam int TA_BIT = 7;
    localparam int PC_W   = 32;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        TRAP_WAIT = 2'd1,
        DRAIN     = 2'd2
    } ex_state_t;

    typedef struct packed {
        logic            valid;
        logic [CW_W-1:0] cw;
        logic [PC_W-1:0] pc;
    } pipe_entry_t;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready skid buffer (main + skid) with a registered in_ready.
module skid_buf2
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  pipe_entry_t in_data,
    output pipe_entry_t out_data,
    input  logic        out_ready,
    input  logic        clear
);
    pipe_entry_t main_reg, main_next;
    pipe_entry_t skid_reg, skid_next;
    logic        in_ready_reg;
    logic        in_fire;
    logic        out_fire;

    assign in_fire  = in_valid & in_ready_reg;
    assign out_fire = main_reg.valid & out_ready;

    always_comb begin
        main_next = main_reg;
        skid_next = skid_reg;
        if (clear) begin
            main_next.valid = 1'b0;
            skid_next.valid = 1'b0;
        end else if (skid_reg.valid) begin
            // in_ready is low whenever skid is occupied, so only a drain can happen here
            if (out_fire) begin
                main_next       = skid_reg;
                skid_next.valid = 1'b0;
            end
        end else if (main_reg.valid && !out_fire) begin
            if (in_fire) begin
                skid_next       = in_data;
                skid_next.valid = 1'b1;
            end
        end else if (in_fire) begin
            main_next       = in_data;
            main_next.valid = 1'b1;
        end else begin
            main_next.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_reg     <= '0;
            skid_reg     <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            main_reg     <= main_next;
            skid_reg     <= skid_next;
            in_ready_reg <= ~skid_next.valid;
        end
    end

    assign in_ready = in_ready_reg;
    assign out_data = main_reg;
endmodule

// File: rtl/ex_stage_reg.sv
// EX-stage input register: skid-buffered control word from ID plus the trap-always sequencer.
module ex_stage_reg
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [CW_W-1:0] id_cw,
    input  logic [PC_W-1:0] id_pc,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [CW_W-1:0] ex_cw,
    output logic [PC_W-1:0] ex_pc,
    input  logic            flush,
    output logic            trap_req,
    output logic [PC_W-1:0] trap_pc,
    input  logic            trap_ack,
    output logic [CNT_W-1:0] trap_cnt
);
    localparam int DC_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

    ex_state_t        state_reg;
    logic             trap_req_reg;
    logic [PC_W-1:0]  trap_pc_reg;
    logic [CNT_W-1:0] trap_cnt_reg;
    logic [DC_W-1:0]  drain_cnt_reg;

    pipe_entry_t buf_in, buf_out;
    logic        buf_in_ready;
    logic        main_is_ta;
    logic        take_trap;

    assign main_is_ta = buf_out.valid & buf_out.cw[TA_BIT];
    assign take_trap  = (state_reg == RUN) & main_is_ta & ~flush;

    assign buf_in = '{valid: id_valid, cw: id_cw, pc: id_pc};

    // Entries accepted outside RUN are squashed younger instructions; they are acked but not stored.
    skid_buf2 u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (id_valid & (state_reg == RUN)),
        .in_ready  (buf_in_ready),
        .in_data   (buf_in),
        .out_data  (buf_out),
        .out_ready (ex_ready & ~buf_out.cw[TA_BIT]),
        .clear     (flush | take_trap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RUN;
            trap_req_reg  <= 1'b0;
            trap_pc_reg   <= '0;
            trap_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (take_trap) begin
                        state_reg    <= TRAP_WAIT;
                        trap_req_reg <= 1'b1;
                        trap_pc_reg  <= buf_out.pc;
                        if (trap_cnt_reg != '1)
                            trap_cnt_reg <= trap_cnt_reg + 1'b1;
                    end
                end
                TRAP_WAIT: begin
                    if (trap_ack) begin
                        trap_req_reg <= 1'b0;
                        if (DRAIN_CYC == 0) begin
                            state_reg <= RUN;
                        end else begin
                            state_reg     <= DRAIN;
                            drain_cnt_reg <= DC_W'(DRAIN_CYC);
                        end
                    end
                end
                DRAIN: begin
                    if (flush || drain_cnt_reg <= 1)
                        state_reg <= RUN;
                    else
                        drain_cnt_reg <= drain_cnt_reg - 1'b1;
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    assign id_ready = buf_in_ready & (state_reg != TRAP_WAIT);
    assign ex_valid = buf_out.valid & ~buf_out.cw[TA_BIT];
    assign ex_cw    = buf_out.cw;
    assign ex_pc    = buf_out.pc;
    assign trap_req = trap_req_reg;
    assign trap_pc  = trap_pc_reg;
    assign trap_cnt = trap_cnt_reg;
endmodule

// File: tb/tb_ex_stage_reg.sv
// Directed bench for ex_stage_reg with a scoreboard of entries expected on the EX side.
module tb_ex_stage_reg;
    import pipe_pkg::*;

    localparam int DRAIN = 2;
    localparam int CNTW  = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            id_valid = 1'b0;
    logic            id_ready;
    logic [CW_W-1:0] id_cw = '0;
    logic [PC_W-1:0] id_pc = '0;
    logic            ex_valid;
    logic            ex_ready = 1'b1;
    logic [CW_W-1:0] ex_cw;
    logic [PC_W-1:0] ex_pc;
    logic            flush = 1'b0;
    logic            trap_req;
    logic [PC_W-1:0] trap_pc;
    logic            trap_ack = 1'b0;
    logic [CNTW-1:0] trap_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    logic [CW_W+PC_W-1:0] sb[$];

    ex_stage_reg #(.DRAIN_CYC(DRAIN), .CNT_W(CNTW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready), .id_cw(id_cw), .id_pc(id_pc),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_cw(ex_cw), .ex_pc(ex_pc),
        .flush(flush), .trap_req(trap_req), .trap_pc(trap_pc), .trap_ack(trap_ack),
        .trap_cnt(trap_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one entry for one cycle; id_ready is register-driven so sampling it here is safe.
    task automatic push_cycle(input logic v, input logic [CW_W-1:0] cw, input logic [PC_W-1:0] pc,
                              input bit deliver, output bit fired);
        id_valid = v;
        id_cw    = cw;
        id_pc    = pc;
        fired    = v && id_ready;
        if (fired && deliver)
            sb.push_back({cw, pc});
        cyc();
        id_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ex_valid === 1'b1 && ex_ready === 1'b1) begin
            $display("xfer cw=%05h pc=%08h", ex_cw, ex_pc);
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0)
                check("ex_entry", 64'({ex_cw, ex_pc}), 64'(sb.pop_front()));
        end
    end

    initial begin
        bit fired;
        bit seen;
        int exp_cnt;

        // Reset state
        repeat (2) cyc();
        reset = 1'b0;
        check("rst_id_ready", 64'(id_ready), 64'd1);
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_ex_cw",    64'(ex_cw),    64'd0);
        check("rst_ex_pc",    64'(ex_pc),    64'd0);
        check("rst_trap_req", 64'(trap_req), 64'd0);
        check("rst_trap_pc",  64'(trap_pc),  64'd0);
        check("rst_trap_cnt", 64'(trap_cnt), 64'd0);

        // Full-throughput stream
        for (int i = 1; i <= 4; i++) begin
            push_cycle(1'b1, CW_W'(i), PC_W'(32'h1000 + 4 * i), 1'b1, fired);
            check("stream_fired", 64'(fired), 64'd1);
            check("stream_valid", 64'(ex_valid), 64'd1);
            check("stream_cw",    64'(ex_cw), 64'(i));
        end
        cyc();
        check("stream_idle", 64'(ex_valid), 64'd0);

        // Backpressure fills main and skid
        ex_ready = 1'b0;
        push_cycle(1'b1, 17'h00021, 32'h2000, 1'b1, fired);
        check("bp_a_fired", 64'(fired), 64'd1);
        push_cycle(1'b1, 17'h00022, 32'h2004, 1'b1, fired);
        check("bp_b_fired", 64'(fired), 64'd1);
        check("bp_hold_cw", 64'(ex_cw), 64'h21);
        push_cycle(1'b1, 17'h00023, 32'h2008, 1'b1, fired);
        check("bp_c_blocked", 64'(fired), 64'd0);
        check("bp_hold_cw2",  64'(ex_cw), 64'h21);
        check("bp_id_ready",  64'(id_ready), 64'd0);
        ex_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            push_cycle(1'b1, 17'h00023, 32'h2008, 1'b1, fired);
            seen = fired;
        end
        check("bp_c_accepted", 64'(seen), 64'd1);
        repeat (3) cyc();

        // ta followed by a younger entry
        push_cycle(1'b1, 17'h00080, 32'h100, 1'b0, fired);
        check("ta_fired", 64'(fired), 64'd1);
        check("ta_not_offered", 64'(ex_valid), 64'd0);
        push_cycle(1'b1, 17'h00001, 32'h104, 1'b0, fired);
        check("trap_req_set", 64'(trap_req), 64'd1);
        check("trap_pc_set",  64'(trap_pc),  64'h100);
        check("trap_id_ready", 64'(id_ready), 64'd0);
        check("trap_cnt_1",   64'(trap_cnt), 64'd1);
        repeat (3) cyc();
        check("trap_req_held", 64'(trap_req), 64'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("flush_tw_req", 64'(trap_req), 64'd1);
        check("flush_tw_pc",  64'(trap_pc),  64'h100);
        trap_ack = 1'b1;
        cyc();
        trap_ack = 1'b0;
        check("ack_req_drop",  64'(trap_req), 64'd0);
        check("drain_id_ready", 64'(id_ready), 64'd1);
        push_cycle(1'b1, 17'h00031, 32'h300, 1'b0, fired);
        check("drain_e1_fired", 64'(fired), 64'd1);
        push_cycle(1'b1, 17'h00032, 32'h304, 1'b0, fired);
        check("drain_e2_fired", 64'(fired), 64'd1);
        push_cycle(1'b1, 17'h00033, 32'h308, 1'b1, fired);
        check("drain_e3_fired", 64'(fired), 64'd1);
        check("drain_e3_cw",    64'(ex_cw), 64'h33);
        check("drain_e3_valid", 64'(ex_valid), 64'd1);
        repeat (2) cyc();

        // Flush with both entries full, then flush with a same-cycle transfer
        ex_ready = 1'b0;
        push_cycle(1'b1, 17'h00011, 32'h400, 1'b0, fired);
        push_cycle(1'b1, 17'h00012, 32'h404, 1'b0, fired);
        check("full_id_ready", 64'(id_ready), 64'd0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("flush_ex_valid", 64'(ex_valid), 64'd0);
        check("flush_id_ready", 64'(id_ready), 64'd1);
        push_cycle(1'b1, 17'h00013, 32'h408, 1'b0, fired);
        check("flush_z_valid", 64'(ex_valid), 64'd1);
        flush = 1'b1;
        push_cycle(1'b1, 17'h00014, 32'h40c, 1'b0, fired);
        flush = 1'b0;
        check("flush_w_fired", 64'(fired), 64'd1);
        check("flush_w_drop",  64'(ex_valid), 64'd0);
        cyc();
        check("flush_w_gone",  64'(ex_valid), 64'd0);
        ex_ready = 1'b1;
        push_cycle(1'b1, 17'h00015, 32'h410, 1'b1, fired);
        repeat (2) cyc();

        // Reset while waiting for trap_ack
        push_cycle(1'b1, 17'h00080, 32'h200, 1'b0, fired);
        cyc();
        check("tw2_req", 64'(trap_req), 64'd1);
        check("tw2_cnt", 64'(trap_cnt), 64'd2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst_tw_req",      64'(trap_req), 64'd0);
        check("rst_tw_cnt",      64'(trap_cnt), 64'd0);
        check("rst_tw_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_tw_id_ready", 64'(id_ready), 64'd1);

        // Counter saturation
        for (int i = 0; i < 260; i++) begin
            push_cycle(1'b1, 17'h00080, PC_W'(32'h8000 + 4 * i), 1'b0, fired);
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                if (trap_req) seen = 1'b1;
                else cyc();
            end
            check("sat_trap_req", 64'(seen), 64'd1);
            check("sat_trap_pc", 64'(trap_pc), 64'(32'h8000 + 4 * i));
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            check("sat_trap_cnt", 64'(trap_cnt), 64'(exp_cnt));
            trap_ack = 1'b1;
            cyc();
            trap_ack = 1'b0;
            repeat (DRAIN) cyc();
        end
        check("sat_final", 64'(trap_cnt), 64'd255);

        repeat (3) cyc();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
